// File: rtl/display_timings_480p.sv
// Raster timing generator for 640x480@60: counters, syncs, data-enable and strobes.
// Every output is registered, and each decode is computed from the coordinates it is registered with.
module display_timings_480p #(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             locked,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic [7:0]       frame_num
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_MAX    = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_MAX    = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_START = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_START = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC);
    localparam logic             HS_ON    = (H_POL != 0);
    localparam logic             VS_ON    = (V_POL != 0);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             de_q, de_d, line_q, line_d, frame_q, frame_d;
    logic [7:0]       fnum_q, fnum_d;
    logic             run_d;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            hs_q    <= !HS_ON;
            vs_q    <= !VS_ON;
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fnum_q  <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            fnum_q  <= fnum_d;
        end
    end

    // Next coordinates first, then the decodes of those same coordinates, so nothing skews.
    always_comb begin
        state_d = state_q;
        sx_d    = '0;
        sy_d    = '0;
        fnum_d  = fnum_q;
        run_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (locked) begin
                    state_d = RUN;
                    run_d   = 1'b1;
                end
            end
            RUN: begin
                if (!locked) begin
                    state_d = IDLE;
                end else begin
                    run_d = 1'b1;
                    if (sx_q == H_MAX) begin
                        if (sy_q == V_MAX) begin
                            fnum_d = fnum_q + 8'd1;
                        end else begin
                            sy_d = sy_q + CORDW'(1);
                        end
                    end else begin
                        sx_d = sx_q + CORDW'(1);
                        sy_d = sy_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        de_d    = run_d && (sx_d < H_ACT) && (sy_d < V_ACT);
        hs_d    = (run_d && (sx_d >= HS_START) && (sx_d < HS_END)) ? HS_ON : !HS_ON;
        vs_d    = (run_d && (sy_d >= VS_START) && (sy_d < VS_END)) ? VS_ON : !VS_ON;
        line_d  = run_d && (sx_d == '0);
        frame_d = run_d && (sx_d == '0) && (sy_d == '0);
    end

    assign sx        = sx_q;
    assign sy        = sy_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign de        = de_q;
    assign line      = line_q;
    assign frame     = frame_q;
    assign frame_num = fnum_q;

endmodule

// File: tb/tb_display_timings_480p.sv
// Randomized lock-drop bench for display_timings_480p: a 640x480 instance and a tiny
// inverted-polarity instance, both checked by a scoreboard against a cycle-count raster model.
module tb_display_timings_480p;

    typedef struct {
        int hres; int hfp; int hsync; int hbp;
        int vres; int vfp; int vsync; int vbp;
        bit hpol; bit vpol;
    } cfg_t;

    typedef struct {
        int sx; int sy;
        bit hs; bit vs; bit de; bit ln; bit fr;
        int fn;
    } obs_t;

    cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_t cfg_s = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lk_d = 1'b0, lk_s = 1'b0;
    logic [9:0] sx_d, sy_d, sx_s, sy_s;
    logic       hs_d, vs_d, de_d, ln_d, fr_d;
    logic       hs_s, vs_s, de_s, ln_s, fr_s;
    logic [7:0] fn_d, fn_s;

    int checks = 0;
    int errors = 0;

    obs_t q_d[$];
    obs_t q_s[$];

    always #5 clk = ~clk;

    display_timings_480p dut_d (
        .clk_pix(clk), .rst(rst), .locked(lk_d),
        .sx(sx_d), .sy(sy_d), .hsync(hs_d), .vsync(vs_d),
        .de(de_d), .line(ln_d), .frame(fr_d), .frame_num(fn_d)
    );

    display_timings_480p #(
        .CORDW(10), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1), .V_POL(1)
    ) dut_s (
        .clk_pix(clk), .rst(rst), .locked(lk_s),
        .sx(sx_s), .sy(sy_s), .hsync(hs_s), .vsync(vs_s),
        .de(de_s), .line(ln_s), .frame(fr_s), .frame_num(fn_s)
    );

    // Raster position as a pure function of cycles elapsed since the run started.
    function automatic obs_t model(input cfg_t c, input bit run, input int t, input int fn);
        obs_t o;
        int ht, vt, x, y;
        ht = c.hres + c.hfp + c.hsync + c.hbp;
        vt = c.vres + c.vfp + c.vsync + c.vbp;
        o.fn = fn;
        if (!run) begin
            o.sx = 0; o.sy = 0; o.hs = !c.hpol; o.vs = !c.vpol;
            o.de = 0; o.ln = 0; o.fr = 0;
        end else begin
            x = t % ht;
            y = (t / ht) % vt;
            o.sx = x;
            o.sy = y;
            o.de = (x < c.hres) && (y < c.vres);
            o.hs = (x >= c.hres + c.hfp && x < c.hres + c.hfp + c.hsync) ? c.hpol : !c.hpol;
            o.vs = (y >= c.vres + c.vfp && y < c.vres + c.vfp + c.vsync) ? c.vpol : !c.vpol;
            o.ln = (x == 0);
            o.fr = (x == 0) && (y == 0);
        end
        return o;
    endfunction

    function automatic int frame_len(input cfg_t c);
        return (c.hres + c.hfp + c.hsync + c.hbp) * (c.vres + c.vfp + c.vsync + c.vbp);
    endfunction

    function automatic bit same(input obs_t a, input obs_t e);
        return a.sx == e.sx && a.sy == e.sy && a.hs == e.hs && a.vs == e.vs &&
               a.de == e.de && a.ln == e.ln && a.fr == e.fr && a.fn == e.fn;
    endfunction

    function automatic obs_t pack(input logic [9:0] x, input logic [9:0] y, input logic h,
                                  input logic v, input logic d, input logic l, input logic f,
                                  input logic [7:0] n);
        obs_t o;
        o.sx = int'(x); o.sy = int'(y); o.hs = h; o.vs = v;
        o.de = d; o.ln = l; o.fr = f; o.fn = int'(n);
        return o;
    endfunction

    task automatic compare(input string name, input obs_t a, input obs_t e);
        checks++;
        if (!same(a, e)) begin
            errors++;
            $display("FAIL %s @%0t got sx=%0d sy=%0d hs=%0b vs=%0b de=%0b line=%0b frame=%0b fnum=%0d want sx=%0d sy=%0d hs=%0b vs=%0b de=%0b line=%0b frame=%0b fnum=%0d",
                     name, $time, a.sx, a.sy, a.hs, a.vs, a.de, a.ln, a.fr, a.fn,
                     e.sx, e.sy, e.hs, e.vs, e.de, e.ln, e.fr, e.fn);
        end
    endtask

    // Model state per instance.
    bit run_md = 0, run_ms = 0;
    int t_md = 0, t_ms = 0;
    int fn_md = 0, fn_ms = 0;
    int frames_s = 0;

    task automatic step(input bit r, input bit lk, input int flen,
                        inout bit run, inout int t, inout int fn, inout int total);
        if (r) begin
            run = 0; fn = 0;
        end else if (!lk) begin
            run = 0;
        end else if (!run) begin
            run = 1; t = 0;
        end else begin
            t++;
            if (t % flen == 0) begin
                fn = (fn + 1) % 256;
                total++;
            end
        end
    endtask

    int dummy = 0;

    // Sample the inputs the DUT saw at this edge, queue the expected outputs, then move inputs.
    task automatic tick();
        @(posedge clk);
        step(rst, lk_d, frame_len(cfg_d), run_md, t_md, fn_md, dummy);
        step(rst, lk_s, frame_len(cfg_s), run_ms, t_ms, fn_ms, frames_s);
        q_d.push_back(model(cfg_d, run_md, t_md, fn_md));
        q_s.push_back(model(cfg_s, run_ms, t_ms, fn_ms));
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q_d.size() > 0)
                compare("raster640", pack(sx_d, sy_d, hs_d, vs_d, de_d, ln_d, fr_d, fn_d), q_d.pop_front());
            if (q_s.size() > 0)
                compare("rastersmall", pack(sx_s, sy_s, hs_s, vs_s, de_s, ln_s, fr_s, fn_s), q_s.pop_front());
        end
    end

    initial begin
        int off_d, off_s, cyc;
        bit directed_done;
        obs_t now_s;
        off_d = 0; off_s = 0; directed_done = 0;

        repeat (3) tick();
        rst = 1'b0;
        repeat (100) tick();
        lk_d = 1'b1;
        lk_s = 1'b1;

        cyc = 0;
        while (cyc < 60000 && !(frames_s >= 258 && cyc >= 2000)) begin
            tick();
            cyc++;
            // Small raster: one forced drop mid-hsync inside vsync, plus random drops.
            now_s = model(cfg_s, run_ms, t_ms, fn_ms);
            if (off_s > 0) begin
                off_s--;
                lk_s = (off_s == 0);
            end else if (!directed_done && run_ms && now_s.sx == 12 && now_s.sy == 5) begin
                directed_done = 1;
                off_s = 3;
                lk_s = 1'b0;
            end else if ($urandom_range(0, 1999) == 0) begin
                off_s = $urandom_range(1, 6);
                lk_s = 1'b0;
            end
            // Full-size raster: leave the first two lines undisturbed, then random drops.
            if (off_d > 0) begin
                off_d--;
                lk_d = (off_d == 0);
            end else if (cyc > 2000 && $urandom_range(0, 2999) == 0) begin
                off_d = $urandom_range(1, 6);
                lk_d = 1'b0;
            end
        end

        lk_d = 1'b1;
        lk_s = 1'b1;
        repeat (50) tick();

        // Async reset between edges must take effect before the next clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        compare("async_rst640", pack(sx_d, sy_d, hs_d, vs_d, de_d, ln_d, fr_d, fn_d),
                model(cfg_d, 1'b0, 0, 0));
        compare("async_rstsmall", pack(sx_s, sy_s, hs_s, vs_s, de_s, ln_s, fr_s, fn_s),
                model(cfg_s, 1'b0, 0, 0));

        checks++;
        if (q_d.size() != 0 || q_s.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", q_d.size(), q_s.size());
        end
        checks++;
        if (frames_s < 258 || !directed_done) begin
            errors++;
            $display("FAIL coverage got frames=%0d directed=%0b want frames>=258 directed=1",
                     frames_s, directed_done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
